// File: rtl/ps2_message_builder.sv
// PS/2 scan-code to ASCII message buffer with make/break decoding, backspace editing
// and a send/acknowledge freeze. Optional shift tracking enabled by `define PS2_SHIFT_EN.
module ps2_message_builder #(
   parameter int unsigned MSG_CHARS = 16,
   parameter logic [7:0]  PAD_CHAR  = 8'h20
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [7:0]                         key_code,
   input  logic                               key_valid,
   input  logic                               send_req,
   input  logic                               tx_done,
   output logic [8*MSG_CHARS-1:0]             message,
   output logic [$clog2(MSG_CHARS+1)-1:0]     msg_len,
   output logic                               msg_ready,
   output logic [7:0]                         char_out,
   output logic                               char_valid,
   output logic                               full,
   output logic                               drop_pulse
);

   localparam int unsigned LEN_W = $clog2(MSG_CHARS + 1);

   localparam logic [7:0] CODE_EXT    = 8'hE0;
   localparam logic [7:0] CODE_BRK    = 8'hF0;
   localparam logic [7:0] CODE_BKSP   = 8'h66;
   localparam logic [7:0] CODE_ENTER  = 8'h5A;
   localparam logic [7:0] ASCII_DEL   = 8'h7F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXT   = 2'd1,
      ST_BREAK = 2'd2
   } dec_state_t;

   dec_state_t state, state_next;

   logic [7:0] slots [MSG_CHARS];

   logic       make_valid;
   logic [7:0] make_ascii;
   logic       is_print;
   logic       is_bksp;
   logic       is_enter;
   logic       do_clear;
   logic       do_send;
   logic       blocked;
   logic       do_append;
   logic       do_bksp;
   logic       do_drop;

`ifdef PS2_SHIFT_EN
   localparam logic [7:0] CODE_LSHIFT = 8'h12;
   localparam logic [7:0] CODE_RSHIFT = 8'h59;

   logic shift_l, shift_r;
   logic shift_l_next, shift_r_next;
`endif

   // Unshifted scan-code set 2 to ASCII; 8'h00 marks a non-printable/unmapped code.
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      logic [7:0] a;
      case (code)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   // Decode FSM next state plus all buffer actions for this cycle.
   always_comb begin
      state_next = state;
      make_valid = 1'b0;
`ifdef PS2_SHIFT_EN
      shift_l_next = shift_l;
      shift_r_next = shift_r;
`endif

      case (state)
         ST_IDLE: begin
            if (key_valid) begin
               if (key_code == CODE_EXT)      state_next = ST_EXT;
               else if (key_code == CODE_BRK) state_next = ST_BREAK;
               else                           make_valid = 1'b1;
            end
         end
         ST_EXT: begin
            if (key_valid) state_next = (key_code == CODE_BRK) ? ST_BREAK : ST_IDLE;
         end
         ST_BREAK: begin
            if (key_valid) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      make_ascii = scan_to_ascii(key_code);

`ifdef PS2_SHIFT_EN
      if (make_valid && key_code == CODE_LSHIFT) shift_l_next = 1'b1;
      if (make_valid && key_code == CODE_RSHIFT) shift_r_next = 1'b1;
      if (state == ST_BREAK && key_valid && key_code == CODE_LSHIFT) shift_l_next = 1'b0;
      if (state == ST_BREAK && key_valid && key_code == CODE_RSHIFT) shift_r_next = 1'b0;
      if ((shift_l || shift_r) && make_ascii >= 8'h61 && make_ascii <= 8'h7A)
         make_ascii = make_ascii - 8'h20;
`endif

      is_print = make_valid && (make_ascii != 8'h00);
      is_bksp  = make_valid && (key_code == CODE_BKSP);
      is_enter = make_valid && (key_code == CODE_ENTER);

      // A clear can only happen while msg_ready is set, so it also blocks appends.
      do_clear  = tx_done && msg_ready;
      do_send   = (send_req || is_enter) && !msg_ready && (msg_len != '0);
      blocked   = msg_ready || do_send || full;
      do_append = is_print && !blocked;
      do_drop   = is_print && blocked;
      do_bksp   = is_bksp && !msg_ready && !do_send && (msg_len != '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         msg_len    <= '0;
         msg_ready  <= 1'b0;
         char_out   <= 8'h00;
         char_valid <= 1'b0;
         drop_pulse <= 1'b0;
         for (int i = 0; i < int'(MSG_CHARS); i++) slots[i] <= PAD_CHAR;
`ifdef PS2_SHIFT_EN
         shift_l    <= 1'b0;
         shift_r    <= 1'b0;
`endif
      end else begin
         state      <= state_next;
         char_valid <= do_append || do_bksp;
         drop_pulse <= do_drop;
`ifdef PS2_SHIFT_EN
         shift_l    <= shift_l_next;
         shift_r    <= shift_r_next;
`endif

         if (do_clear) begin
            msg_len   <= '0;
            msg_ready <= 1'b0;
            for (int i = 0; i < int'(MSG_CHARS); i++) slots[i] <= PAD_CHAR;
         end else begin
            if (do_send) msg_ready <= 1'b1;
            if (do_append) begin
               msg_len <= msg_len + LEN_W'(1);
               for (int i = 0; i < int'(MSG_CHARS); i++)
                  if (LEN_W'(i) == msg_len) slots[i] <= make_ascii;
            end else if (do_bksp) begin
               msg_len <= msg_len - LEN_W'(1);
               for (int i = 0; i < int'(MSG_CHARS); i++)
                  if (LEN_W'(i) == msg_len - LEN_W'(1)) slots[i] <= PAD_CHAR;
            end
         end

         if (do_append)    char_out <= make_ascii;
         else if (do_bksp) char_out <= ASCII_DEL;
      end
   end

   // Char 0 occupies the most significant byte.
   always_comb begin
      message = '0;
      for (int i = 0; i < int'(MSG_CHARS); i++)
         message[8*int'(MSG_CHARS)-1-8*i -: 8] = slots[i];
   end

   assign full = (msg_len == LEN_W'(MSG_CHARS));

endmodule
